// File: rtl/mem_pkg.sv
// Shared definitions for the data memory: funct3 encodings, FSM states, widths.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32 loads and stores.
// Store path: replicate data across lanes and derive byte enables.
// Load path: pick the addressed lane and sign/zero extend.
// Misaligned halfwords/words are force-aligned here by ignoring the low address bits.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] store_lanes,
  output logic [3:0]      byte_en,
  input  logic [XLEN-1:0] load_word,
  output logic [XLEN-1:0] load_result
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Store lane replication and byte enables
  always_comb begin
    store_lanes = store_data;
    byte_en     = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        store_lanes = {4{store_data[7:0]}};
        byte_en     = 4'b0001 << addr_lo;
      end
      2'b01: begin
        store_lanes = {2{store_data[15:0]}};
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    case (addr_lo)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_B:    load_result = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_result = {{16{load_half[15]}}, load_half};
      F3_BU:   load_result = {24'b0, load_byte};
      F3_HU:   load_result = {16'b0, load_half};
      default: load_result = load_word;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Word-organised data RAM with wait states, lane alignment and error reporting.
// Optional macro DATA_MEMORY_MISALIGN_TRAP_EN: reject misaligned halfword/word
// accesses instead of force-aligning them.
module data_memory
  import mem_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS  = 1024,
  parameter logic [XLEN-1:0] BASE_ADDRESS = 32'h0000_1000,
  parameter int unsigned     WAIT_CYCLES  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] memory_address,
  input  logic            memory_read,
  input  logic            memory_write,
  input  logic [2:0]      memory_funct3,
  input  logic [XLEN-1:0] memory_write_data,
  output logic [XLEN-1:0] memory_read_data,
  output logic            memory_ready,
  output logic            memory_error
);

  localparam int unsigned     AW       = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] END_ADDR = BASE_ADDRESS + XLEN'(DEPTH_WORDS * 4);

  mem_state_e      state_q;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] wdata_q;
  logic            rd_q;
  logic            wr_q;
  logic            ready_q;
  logic            error_q;
  logic [XLEN-1:0] rdata_q;

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  logic [XLEN-1:0] offset;
  logic [AW-1:0]   idx;
  logic            reject_d;
  logic            mem_we_d;
  logic [XLEN-1:0] store_lanes;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] load_result;
  logic            unused_offset_hi;

  assign offset           = addr_q - BASE_ADDRESS;
  assign idx              = offset[AW+1:2];
  assign unused_offset_hi = &{1'b0, offset[XLEN-1:AW+2], offset[1:0]};

  // Request legality, evaluated on the captured request during ACCESS
  always_comb begin
    reject_d = rd_q & wr_q;
    if (addr_q < BASE_ADDRESS || addr_q >= END_ADDR) reject_d = 1'b1;
    if (wr_q && f3_q > F3_W) reject_d = 1'b1;
    if (rd_q && (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111)) reject_d = 1'b1;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    if (f3_q[1:0] == 2'b01 && addr_q[0]) reject_d = 1'b1;
    if (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) reject_d = 1'b1;
`endif
    mem_we_d = (state_q == S_ACCESS) && wr_q && !reject_d;
  end

  mem_lane_align u_align (
    .addr_lo     (addr_q[1:0]),
    .funct3      (f3_q),
    .store_data  (wdata_q),
    .store_lanes (store_lanes),
    .byte_en     (byte_en),
    .load_word   (mem_q[idx]),
    .load_result (load_result)
  );

  // Array store port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[idx][8*b +: 8] <= store_lanes[8*b +: 8];
      end
    end
  end

  // Request FSM with registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (memory_read || memory_write) begin
            addr_q  <= memory_address;
            f3_q    <= memory_funct3;
            wdata_q <= memory_write_data;
            rd_q    <= memory_read;
            wr_q    <= memory_write;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          ready_q <= 1'b1;
          error_q <= reject_d;
          rdata_q <= (rd_q && !reject_d) ? load_result : '0;
          state_q <= S_RESP;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign memory_ready     = ready_q;
  assign memory_error     = error_q;
  assign memory_read_data = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus randomized traffic
// against a byte-addressed reference model.
module tb_data_memory;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned W     = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] memory_address;
  logic        memory_read;
  logic        memory_write;
  logic [2:0]  memory_funct3;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;
  logic        memory_ready;
  logic        memory_error;

  int errors = 0;
  int checks = 0;
  bit [7:0] mdl [DEPTH*4];

  data_memory #(
    .DEPTH_WORDS  (DEPTH),
    .BASE_ADDRESS (BASE),
    .WAIT_CYCLES  (W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .memory_address    (memory_address),
    .memory_read       (memory_read),
    .memory_write      (memory_write),
    .memory_funct3     (memory_funct3),
    .memory_write_data (memory_write_data),
    .memory_read_data  (memory_read_data),
    .memory_ready      (memory_ready),
    .memory_error      (memory_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-granular memory, access size 1<<funct3[1:0]
  task automatic model(input bit rd, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, output bit err, output logic [31:0] rdv);
    int unsigned size;
    int unsigned off;
    logic [31:0] v;
    size = 1 << f3[1:0];
    err  = rd && wr;
    if (a < BASE || a >= BASE + DEPTH*4) err = 1;
    if (rd && (f3 == 3 || f3 >= 6)) err = 1;
    if (wr && f3 > 2) err = 1;
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    if (a % size != 0) err = 1;
`else
    a = a - a % size;
`endif
    rdv = 0;
    if (!err) begin
      off = a - BASE;
      if (wr) begin
        for (int i = 0; i < int'(size); i++) mdl[off+i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < int'(size); i++) v = v | ({24'b0, mdl[off+i]} << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
        rdv = v;
      end
    end
  endtask

  // One complete handshake; called at a negedge with the DUT idle
  task automatic do_access(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [2:0] f3, input logic [31:0] wd, output logic [31:0] got);
    bit          eerr;
    logic [31:0] erd;
    int          cyc;
    model(rd, wr, a, f3, wd, eerr, erd);
    memory_read       = rd;
    memory_write      = wr;
    memory_address    = a;
    memory_funct3     = f3;
    memory_write_data = wd;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!memory_ready && cyc < 40);
    got = memory_read_data;
    check32({tag, "/lat"}, 32'(cyc), 32'(W + 2));
    check32({tag, "/err"}, 32'(memory_error), 32'(eerr));
    check32({tag, "/data"}, memory_read_data, erd);
    memory_read  = 0;
    memory_write = 0;
    @(negedge clk);
    check32({tag, "/drop"}, 32'({memory_ready, memory_error}), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [2:0]  f3;
    bit          rd, wr;
    int unsigned k;

    rst_n = 0;
    memory_read = 0; memory_write = 0; memory_address = 0;
    memory_funct3 = 0; memory_write_data = 0;
    repeat (3) @(negedge clk);
    check32("rst/ready", 32'(memory_ready), 32'd0);
    check32("rst/error", 32'(memory_error), 32'd0);
    check32("rst/data", memory_read_data, 32'd0);
    rst_n = 1;
    @(negedge clk);

    do_access("sw0", 0, 1, 32'h1000, 3'b010, 32'hDEADBEEF, got);
    do_access("lw0", 1, 0, 32'h1000, 3'b010, 32'h0, got);
    check32("lw0/const", got, 32'hDEADBEEF);
    do_access("sb0", 0, 1, 32'h1002, 3'b000, 32'h0000007F, got);
    do_access("lb0", 1, 0, 32'h1002, 3'b000, 32'h0, got);
    check32("lb0/const", got, 32'h0000007F);
    do_access("lw1", 1, 0, 32'h1000, 3'b010, 32'h0, got);
    check32("lw1/const", got, 32'hDE7FBEEF);
    do_access("lb3", 1, 0, 32'h1003, 3'b000, 32'h0, got);
    check32("lb3/const", got, 32'hFFFFFFDE);
    do_access("lbu3", 1, 0, 32'h1003, 3'b100, 32'h0, got);
    check32("lbu3/const", got, 32'h000000DE);
    do_access("sw1", 0, 1, 32'h1000, 3'b010, 32'h80010000, got);
    do_access("lh2", 1, 0, 32'h1002, 3'b001, 32'h0, got);
    check32("lh2/const", got, 32'hFFFF8001);
    do_access("lhu2", 1, 0, 32'h1002, 3'b101, 32'h0, got);
    check32("lhu2/const", got, 32'h00008001);
    do_access("sw10", 0, 1, 32'h1010, 3'b010, 32'hCAFEF00D, got);

    do_access("lw_lo", 1, 0, 32'h0FFC, 3'b010, 32'h0, got);
    do_access("sw_hi", 0, 1, BASE + DEPTH*4, 3'b010, 32'h55555555, got);
    do_access("rdwr", 1, 1, 32'h1000, 3'b010, 32'h11111111, got);
    do_access("lw_chk", 1, 0, 32'h1000, 3'b010, 32'h0, got);
    check32("lw_chk/const", got, 32'h80010000);

    // Reset during WAIT of a store: no response, store discarded
    memory_write = 1; memory_address = 32'h1010;
    memory_funct3 = 3'b010; memory_write_data = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check32("rstmid/out", {memory_read_data[29:0], memory_ready, memory_error}, 32'd0);
    memory_write = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check32("rstmid/noready", 32'(memory_ready), 32'd0);
    end
    do_access("lw10", 1, 0, 32'h1010, 3'b010, 32'h0, got);
    check32("lw10/const", got, 32'hCAFEF00D);

    do_access("lw_mis", 1, 0, 32'h1002, 3'b010, 32'h0, got);
`ifdef DATA_MEMORY_MISALIGN_TRAP_EN
    check32("lw_mis/const", got, 32'h0);
`else
    check32("lw_mis/const", got, 32'h80010000);
`endif

    // Fill a window so every random load hits modelled bytes
    for (int i = 0; i < 32; i++)
      do_access("init", 0, 1, BASE + 32'(4*i), 3'b010, $urandom, got);

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      a = BASE - 32'(4 * $urandom_range(1, 4));
      else if (k == 1) a = BASE + DEPTH*4 + 32'($urandom_range(0, 15));
      else             a = BASE + 32'($urandom_range(0, 127));
      k = $urandom_range(0, 9);
      rd = (k < 5);
      wr = (k >= 5) || (k == 0);
      f3 = 3'($urandom_range(0, 7));
      do_access("rnd", rd, wr, a, f3, $urandom, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
